// File: rtl/calc_pkg.sv
// Shared definitions for the keypad scanner and the calculator FSM:
// key codes, scanner state encoding and a column priority helper.
package calc_pkg;

    localparam logic [3:0] KEY_EQUAL = 4'd10;
    localparam logic [3:0] KEY_AC    = 4'd11;
    localparam logic [3:0] KEY_PLUS  = 4'd12;
    localparam logic [3:0] KEY_MINUS = 4'd13;
    localparam logic [3:0] KEY_MULT  = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_ASSERT,
        ST_HELD
    } scan_state_e;

    // Index of the lowest active-low column; only meaningful when
    // at least one column is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd3;
        priority case (1'b1)
            !col_n[0]: idx = 2'd0;
            !col_n[1]: idx = 2'd1;
            !col_n[2]: idx = 2'd2;
            default:   idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event bundle from the keypad scanner to the calculator FSM.
// readKey: high while a key is held; pressedkey: its code.
interface keypad_scanner_if;
    import calc_pkg::*;

    logic       readKey;
    logic [3:0] pressedkey;

    modport master (output readKey, output pressedkey);
    modport slave  (input  readKey, input  pressedkey);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones.
// Ports: clk, rst_n (async active-low), d (async in), q (synced out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, debounce, one key event per press.
// Ports: clk, reset (async active-low), col_n in, row_n out,
//        readKey / pressedkey out to the calculator FSM.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       readKey,
    output logic [3:0] pressedkey
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            ONE_TICK = (DEBOUNCE_CNT == 1);

    function automatic logic [3:0] key_map(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_PLUS;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_MINUS;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_MULT;
            4'hC: code = KEY_AC;
            4'hD: code = 4'd0;
            4'hE: code = KEY_EQUAL;
            4'hF: code = KEY_DIV;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    logic [3:0]    col_s;
    scan_state_e   state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          readkey_q, readkey_d;
    logic [3:0]    pressedkey_q, pressedkey_d;

    logic       tick;
    logic       any_low;
    logic [1:0] win_col;
    logic       cand_low;
    logic       same_win;
    logic       cnt_done;
    logic       rcnt_done;

    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (col_n),
        .q     (col_s)
    );

    assign tick     = (div_q == DIV_LAST);
    assign div_d    = tick ? '0 : div_q + 1'b1;
    assign any_low  = (col_s != 4'hF);
    assign win_col  = lowest_low(col_s);
    assign cand_low = !col_s[cand_col_q];
    assign same_win = any_low && (win_col == cand_col_q);
    // The count is bumped on this tick, so reaching the target
    // means the current value is one short of it.
    assign cnt_done  = (cnt_q >= CNT_LAST);
    assign rcnt_done = (rcnt_q >= CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SCAN;
            div_q        <= '0;
            row_idx_q    <= 2'd0;
            row_n_q      <= ROW_RESET;
            cand_col_q   <= 2'd0;
            cnt_q        <= '0;
            rcnt_q       <= '0;
            readkey_q    <= 1'b0;
            pressedkey_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            row_idx_q    <= row_idx_d;
            row_n_q      <= row_n_d;
            cand_col_q   <= cand_col_d;
            cnt_q        <= cnt_d;
            rcnt_q       <= rcnt_d;
            readkey_q    <= readkey_d;
            pressedkey_q <= pressedkey_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (tick && any_low)
                    state_d = ONE_TICK ? ST_ASSERT : ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!same_win)
                        state_d = ST_SCAN;
                    else if (cnt_done)
                        state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: state_d = ST_HELD;
            ST_HELD: begin
                if (tick && !cand_low && rcnt_done)
                    state_d = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_comb begin
        row_idx_d    = row_idx_q;
        cand_col_d   = cand_col_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        readkey_d    = readkey_q;
        pressedkey_d = pressedkey_q;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (!any_low) begin
                        row_idx_d = row_idx_q + 2'd1;
                    end else begin
                        cand_col_d = win_col;
                        cnt_d      = CNT_ONE;
                        if (ONE_TICK)
                            pressedkey_d = key_map(row_idx_q, win_col);
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!same_win) begin
                        cnt_d = '0;
                    end else if (cnt_done) begin
                        cnt_d        = CNT_FULL;
                        pressedkey_d = key_map(row_idx_q, cand_col_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // pressedkey was loaded on entry, so it leads readKey
            // by exactly this one cycle.
            ST_ASSERT: readkey_d = 1'b1;
            ST_HELD: begin
                if (tick) begin
                    if (cand_low) begin
                        rcnt_d = '0;
                    end else if (rcnt_done) begin
                        rcnt_d    = '0;
                        cnt_d     = '0;
                        readkey_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                readkey_d = 1'b0;
            end
        endcase
    end

    assign row_n_d = ~(4'b0001 << row_idx_d);

    keypad_scanner_if key_if ();

    assign key_if.readKey    = readkey_q;
    assign key_if.pressedkey = pressedkey_q;

    assign row_n      = row_n_q;
    assign readKey    = key_if.readKey;
    assign pressedkey = key_if.pressedkey;

endmodule
